round_controller: RTL and testbench
===================================

// Module: round_controller
// PURPOSE
//  Game-round sequencer sitting above the gem/score datapath. Runs the title -> play -> win/lose
//  flow, clears every gem instance at round start, counts collected gems from the per-gem
//  dead flags, keeps a frame-driven elapsed-seconds timer and freezes players outside play.
//  Feeds the score digit renderer and the player motion controllers.
// PARAMETERS
//  GEM_COUNT        2    number of gem instances monitored (1..15)
//  FRAMES_PER_SEC   60   frame_tick pulses per timer second
//  TIME_LIMIT       300  seconds allowed per round; 0 = no limit
//  DOOR_HOLD        30   consecutive frames both players must be at doors to win
//  CLEAR_CYCLES     4    cycles gem_clear is held high at round start
// PORTS
//  Clk         in   1          system clock
//  Reset       in   1          asynchronous, active-low reset
//  frame_tick  in   1          one-cycle pulse per video frame (vsync edge)
//  start_btn   in   1          level from keycode decode; rising edge acts
//  gem_dead    in   GEM_COUNT  per-gem collected flag (sticky until cleared)
//  p1_at_door  in   1          player 1 overlaps its exit door
//  p2_at_door  in   1          player 2 overlaps its exit door
//  hazard_hit  in   1          either player touched a lethal tile
//  gem_clear   out  1          synchronous reset to gem instances
//  score       out  4          gems collected this round, saturates at 15
//  seconds     out  10         elapsed round seconds, saturates at 999
//  state       out  3          round_state_t encoding for HUD/overlay
//  freeze      out  1          players ignore input when high
//  round_win   out  1          high while in WIN
//  round_lose  out  1          high while in LOSE
// BEHAVIOUR
//  - Reset low: state=IDLE, score=0, seconds=0, gem_clear=0, freeze=1, win/lose=0, all counters 0.
//  - All outputs registered; every transition takes effect the cycle after its cause.
//  - start edge: start_btn registered, edge = cur & ~prev; level hold never retriggers.
//  - IDLE: freeze=1; start edge -> CLEAR.
//  - CLEAR: gem_clear=1 for exactly CLEAR_CYCLES cycles; score, seconds, frame and door
//    counters zeroed; then -> PLAY. gem_dead inputs ignored in CLEAR.
//  - PLAY: freeze=0. Gem count: gem_dead registered; each 0->1 bit adds 1 (several bits
//    same cycle add popcount); saturate at 15; 1->0 never decrements.
//  - Timer: frame counter advances on frame_tick; at FRAMES_PER_SEC-1 wraps to 0 and
//    seconds++ (saturate 999). Timer halts outside PLAY.
//  - Door hold: on frame_tick, both at door -> door_cnt++, else door_cnt=0;
//    door_cnt reaching DOOR_HOLD -> WIN.
//  - hazard_hit in PLAY -> LOSE; seconds==TIME_LIMIT (limit!=0) -> LOSE.
//  - Priority in same cycle: hazard > timeout > win.
//  - WIN / LOSE: freeze=1, score and seconds held for HUD; start edge -> CLEAR.
//  - start edge in PLAY ignored (no mid-round restart).
//  - Reset asserted in any state aborts immediately to IDLE; gem_clear drops asynchronously.
//  - Unreachable state encodings recover to IDLE on next clock.
// STRUCTURE
//  - Package game_pkg: round_state_t enum {IDLE, CLEAR, PLAY, WIN, LOSE} (3 bits),
//    SCORE_W=4, SECONDS_W=10, SECONDS_MAX=999.
//  - One sub-module: round_timer (frame prescaler + saturating seconds counter,
//    inputs run/clear/frame_tick, output seconds). FSM, gem edge count, door hold stay top-level.
// TESTING (bench: FRAMES_PER_SEC=4, TIME_LIMIT=5, DOOR_HOLD=3, CLEAR_CYCLES=4, GEM_COUNT=2)
//  - Reset low mid-PLAY with score=2 -> state=IDLE, score=0, seconds=0, freeze=1 same cycle.
//  - start pulse in IDLE -> gem_clear high exactly 4 cycles, then state=PLAY, freeze=0;
//    holding start_btn high 100 cycles causes no second CLEAR.
//  - gem_dead 00->11 in one cycle -> score=2; then 11->10 -> score stays 2; clear -> 0.
//  - 20 frame_ticks in PLAY -> seconds=5 -> state=LOSE, round_lose=1, seconds held at 5.
//  - both at door for 3 frame_ticks -> WIN; door dropped on tick 2 -> counter restarts, no WIN.
//  - hazard_hit and 3rd door tick same cycle -> LOSE; start edge in LOSE -> CLEAR -> PLAY, score=0.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg
// Shared types and constants for the round sequencer and its HUD consumers.
//   round_state_t : 3-bit round phase encoding, also driven out for the overlay
//   SCORE_W / SCORE_MAX       : gem score width and saturation value
//   SECONDS_W / SECONDS_MAX   : elapsed-time width and saturation value
//   gem_popcount()            : number of set bits in a gem flag vector (<= 15 gems)
package game_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        PLAY  = 3'd2,
        WIN   = 3'd3,
        LOSE  = 3'd4
    } round_state_t;

    localparam int SCORE_W     = 4;
    localparam int SCORE_MAX   = 15;
    localparam int SECONDS_W   = 10;
    localparam int SECONDS_MAX = 999;

    function automatic logic [3:0] gem_popcount(input logic [14:0] bits);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 15; i++) begin
            cnt = cnt + {3'd0, bits[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/round_timer.sv
// round_timer
// Frame-driven elapsed-seconds counter for one game round.
//   Clk        in   system clock
//   Reset      in   asynchronous active-low reset
//   run        in   count frames only while high
//   clear      in   zero both the frame prescaler and the seconds count
//   frame_tick in   one-cycle pulse per video frame
//   seconds    out  elapsed seconds, saturating at SECONDS_MAX
module round_timer
    import game_pkg::*;
#(
    parameter int FRAMES_PER_SEC = 60
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 run,
    input  logic                 clear,
    input  logic                 frame_tick,
    output logic [SECONDS_W-1:0] seconds
);

    localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

    logic [FW-1:0] frame_cnt;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            frame_cnt <= '0;
            seconds   <= '0;
        end else if (clear) begin
            frame_cnt <= '0;
            seconds   <= '0;
        end else if (run && frame_tick) begin
            if (frame_cnt == FW'(FRAMES_PER_SEC - 1)) begin
                frame_cnt <= '0;
                if (seconds != SECONDS_W'(SECONDS_MAX)) begin
                    seconds <= seconds + 1'b1;
                end
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/round_controller.sv
// round_controller
// Round sequencer above the gem/score datapath: title -> clear -> play -> win/lose.
//   Clk         in   system clock
//   Reset       in   asynchronous active-low reset
//   frame_tick  in   one-cycle pulse per video frame
//   start_btn   in   start key level; only its rising edge acts
//   gem_dead    in   per-gem collected flags (sticky until gem_clear)
//   p1_at_door  in   player 1 overlaps its exit door
//   p2_at_door  in   player 2 overlaps its exit door
//   hazard_hit  in   a player touched a lethal tile
//   gem_clear   out  synchronous reset pulse to every gem instance
//   score       out  gems collected this round, saturating at 15
//   seconds     out  elapsed round seconds, saturating at 999
//   state       out  round_state_t encoding for the HUD overlay
//   freeze      out  players ignore input while high
//   round_win   out  high while in WIN
//   round_lose  out  high while in LOSE
//
// state | meaning
// IDLE  | title screen, waiting for start
// CLEAR | gem_clear asserted, round counters zeroed
// PLAY  | players move, gems/timer/doors tracked
// WIN   | both players held the doors long enough
// LOSE  | hazard touched or time ran out
module round_controller
    import game_pkg::*;
#(
    parameter int GEM_COUNT      = 2,
    parameter int FRAMES_PER_SEC = 60,
    parameter int TIME_LIMIT     = 300,
    parameter int DOOR_HOLD      = 30,
    parameter int CLEAR_CYCLES   = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_tick,
    input  logic                 start_btn,
    input  logic [GEM_COUNT-1:0] gem_dead,
    input  logic                 p1_at_door,
    input  logic                 p2_at_door,
    input  logic                 hazard_hit,
    output logic                 gem_clear,
    output logic [SCORE_W-1:0]   score,
    output logic [SECONDS_W-1:0] seconds,
    output logic [2:0]           state,
    output logic                 freeze,
    output logic                 round_win,
    output logic                 round_lose
);

    localparam int CW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam int DW = $clog2(DOOR_HOLD + 1);

    round_state_t         state_q;
    round_state_t         state_d;
    logic                 start_prev;
    logic [GEM_COUNT-1:0] gem_prev;
    logic [CW-1:0]        clear_cnt;
    logic [DW-1:0]        door_cnt;

    logic                 start_edge;
    logic                 both_at_door;
    logic                 door_done;
    logic                 timeout;
    logic                 round_clear;
    logic [GEM_COUNT-1:0] gem_rise;
    logic [3:0]           gem_new;
    logic [SCORE_W:0]     score_sum;

    assign start_edge   = start_btn & ~start_prev;
    assign both_at_door = p1_at_door & p2_at_door;
    // The win fires on the tick that would bring the hold count to DOOR_HOLD,
    // so it can collide with a hazard in the same cycle.
    assign door_done    = frame_tick & both_at_door & (door_cnt == DW'(DOOR_HOLD - 1));
    assign timeout      = (TIME_LIMIT != 0) && (32'(seconds) == 32'(TIME_LIMIT));
    // Zeroing on entry keeps score/seconds at 0 for every visible CLEAR cycle.
    assign round_clear  = (state_d == CLEAR);
    assign gem_rise     = gem_dead & ~gem_prev;
    assign gem_new      = gem_popcount(15'(gem_rise));
    assign score_sum    = {1'b0, score} + {1'b0, gem_new};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start_edge) state_d = CLEAR;
            CLEAR:    if (clear_cnt == '0) state_d = PLAY;
            PLAY: begin
                if (hazard_hit)     state_d = LOSE;
                else if (timeout)   state_d = LOSE;
                else if (door_done) state_d = WIN;
            end
            WIN, LOSE: if (start_edge) state_d = CLEAR;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            start_prev <= 1'b0;
            gem_prev   <= '0;
            gem_clear  <= 1'b0;
            freeze     <= 1'b1;
            round_win  <= 1'b0;
            round_lose <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_prev <= start_btn;
            gem_prev   <= gem_dead;
            gem_clear  <= (state_d == CLEAR);
            freeze     <= (state_d != PLAY);
            round_win  <= (state_d == WIN);
            round_lose <= (state_d == LOSE);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            clear_cnt <= '0;
        end else if (state_q != CLEAR && state_d == CLEAR) begin
            clear_cnt <= CW'(CLEAR_CYCLES - 1);
        end else if (state_q == CLEAR && clear_cnt != '0) begin
            clear_cnt <= clear_cnt - 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            score <= '0;
        end else if (round_clear) begin
            score <= '0;
        end else if (state_q == PLAY) begin
            if (score_sum > (SCORE_W + 1)'(SCORE_MAX)) begin
                score <= SCORE_W'(SCORE_MAX);
            end else begin
                score <= score_sum[SCORE_W-1:0];
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            door_cnt <= '0;
        end else if (round_clear) begin
            door_cnt <= '0;
        end else if (state_q == PLAY && frame_tick) begin
            if (!both_at_door) begin
                door_cnt <= '0;
            end else if (door_cnt != DW'(DOOR_HOLD)) begin
                door_cnt <= door_cnt + 1'b1;
            end
        end
    end

    round_timer #(
        .FRAMES_PER_SEC(FRAMES_PER_SEC)
    ) u_timer (
        .Clk       (Clk),
        .Reset     (Reset),
        .run       (state_q == PLAY),
        .clear     (round_clear),
        .frame_tick(frame_tick),
        .seconds   (seconds)
    );

    assign state = state_q;

endmodule

// File: tb/tb_round_controller.sv
module tb_round_controller;
    import game_pkg::*;

    localparam int FPS = 4;
    localparam int TL  = 5;
    localparam int DH  = 3;
    localparam int CC  = 4;
    localparam int GC  = 2;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          frame_tick = 1'b0;
    logic          start_btn = 1'b0;
    logic [GC-1:0] gem_dead = '0;
    logic          p1_at_door = 1'b0;
    logic          p2_at_door = 1'b0;
    logic          hazard_hit = 1'b0;
    logic          gem_clear;
    logic [3:0]    score;
    logic [9:0]    seconds;
    logic [2:0]    state;
    logic          freeze;
    logic          round_win;
    logic          round_lose;

    always #5 Clk = ~Clk;

    round_controller #(
        .GEM_COUNT(GC), .FRAMES_PER_SEC(FPS), .TIME_LIMIT(TL),
        .DOOR_HOLD(DH), .CLEAR_CYCLES(CC)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .start_btn(start_btn),
        .gem_dead(gem_dead), .p1_at_door(p1_at_door), .p2_at_door(p2_at_door),
        .hazard_hit(hazard_hit), .gem_clear(gem_clear), .score(score),
        .seconds(seconds), .state(state), .freeze(freeze),
        .round_win(round_win), .round_lose(round_lose)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: round phase, total frames played, door run length.
    round_state_t m_state;
    int           m_clear_left;
    int           m_score;
    int           m_frames;
    int           m_door;
    logic         m_start_prev;
    logic [GC-1:0] m_gem_prev;
    logic         m_edge;
    int           m_rises;
    round_state_t m_next;

    function automatic int m_seconds();
        int s;
        s = m_frames / FPS;
        return (s > 999) ? 999 : s;
    endfunction

    task automatic m_enter_clear();
        m_state      = CLEAR;
        m_clear_left = CC;
        m_score      = 0;
        m_frames     = 0;
        m_door       = 0;
    endtask

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            m_state      = IDLE;
            m_clear_left = 0;
            m_score      = 0;
            m_frames     = 0;
            m_door       = 0;
            m_start_prev = 1'b0;
            m_gem_prev   = '0;
        end else begin
            m_edge  = start_btn && !m_start_prev;
            m_rises = $countones(gem_dead & ~m_gem_prev);
            case (m_state)
                IDLE: if (m_edge) m_enter_clear();
                CLEAR: begin
                    m_clear_left--;
                    if (m_clear_left == 0) m_state = PLAY;
                end
                PLAY: begin
                    m_next = PLAY;
                    if (hazard_hit) m_next = LOSE;
                    else if (TL != 0 && m_seconds() == TL) m_next = LOSE;
                    else if (frame_tick && p1_at_door && p2_at_door && m_door + 1 >= DH) m_next = WIN;
                    m_score = (m_score + m_rises > 15) ? 15 : m_score + m_rises;
                    if (frame_tick) begin
                        m_frames++;
                        m_door = (p1_at_door && p2_at_door) ? m_door + 1 : 0;
                    end
                    m_state = m_next;
                end
                default: if (m_edge) m_enter_clear();
            endcase
            m_start_prev = start_btn;
            m_gem_prev   = gem_dead;
        end
    end

    always @(negedge Clk) begin
        if (Reset) begin
            check("m_state", 32'(state), 32'(m_state));
            check("m_gem_clear", 32'(gem_clear), 32'(m_state == CLEAR));
            check("m_freeze", 32'(freeze), 32'(m_state != PLAY));
            check("m_win", 32'(round_win), 32'(m_state == WIN));
            check("m_lose", 32'(round_lose), 32'(m_state == LOSE));
            check("m_score", 32'(score), 32'(m_score));
            check("m_seconds", 32'(seconds), 32'(m_seconds()));
        end
    end

    task automatic tick();
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        @(negedge Clk);
    endtask

    task automatic pulse_start();
        start_btn = 1'b1;
        @(negedge Clk);
        start_btn = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, input string name);
        int k;
        k = 0;
        while (state !== target && k < budget) begin
            @(negedge Clk);
            k++;
        end
        check(name, 32'(state), 32'(target));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check("rst_state", 32'(state), 32'(IDLE));
        check("rst_freeze", 32'(freeze), 32'd1);
        check("rst_gem_clear", 32'(gem_clear), 32'd0);
        check("rst_score", 32'(score), 32'd0);

        // start pulse: gem_clear for exactly four cycles, then PLAY
        pulse_start();
        n = 0;
        while (gem_clear === 1'b1 && n < 20) begin
            n++;
            @(negedge Clk);
        end
        check("clear_len", 32'(n), 32'd4);
        check("play_state", 32'(state), 32'(PLAY));
        check("play_freeze", 32'(freeze), 32'd0);

        // held start level never restarts the round
        start_btn = 1'b1;
        n = 0;
        repeat (100) begin
            @(negedge Clk);
            if (gem_clear === 1'b1) n++;
        end
        start_btn = 1'b0;
        check("hold_no_retrigger", 32'(n), 32'd0);
        check("hold_state", 32'(state), 32'(PLAY));

        // two gems in one cycle, then a falling flag
        gem_dead = 2'b11;
        repeat (2) @(negedge Clk);
        check("gem_both", 32'(score), 32'd2);
        gem_dead = 2'b10;
        repeat (2) @(negedge Clk);
        check("gem_fall", 32'(score), 32'd2);

        // timeout after 20 frames = 5 seconds
        repeat (20) tick();
        wait_state(LOSE, 5, "timeout_state");
        check("timeout_seconds", 32'(seconds), 32'd5);
        check("timeout_lose", 32'(round_lose), 32'd1);
        check("timeout_score_held", 32'(score), 32'd2);
        repeat (10) @(negedge Clk);
        check("timeout_seconds_held", 32'(seconds), 32'd5);

        // restart from LOSE clears score
        gem_dead = 2'b00;
        pulse_start();
        check("restart_score_clear", 32'(score), 32'd0);
        wait_state(PLAY, 10, "restart_play");
        check("restart_seconds", 32'(seconds), 32'd0);

        // door hold of three ticks wins
        p1_at_door = 1'b1;
        p2_at_door = 1'b1;
        repeat (3) tick();
        check("door_win_state", 32'(state), 32'(WIN));
        check("door_win_flag", 32'(round_win), 32'd1);
        p1_at_door = 1'b0;
        p2_at_door = 1'b0;

        // door dropped on tick 2 restarts the hold
        pulse_start();
        wait_state(PLAY, 10, "door2_play");
        p1_at_door = 1'b1;
        p2_at_door = 1'b1;
        tick();
        p1_at_door = 1'b0;
        tick();
        p1_at_door = 1'b1;
        tick();
        tick();
        check("door_restart_state", 32'(state), 32'(PLAY));
        check("door_restart_nowin", 32'(round_win), 32'd0);
        tick();
        check("door_restart_win", 32'(state), 32'(WIN));
        p1_at_door = 1'b0;
        p2_at_door = 1'b0;

        // hazard beats the winning door tick
        pulse_start();
        wait_state(PLAY, 10, "haz_play");
        gem_dead = 2'b01;
        p1_at_door = 1'b1;
        p2_at_door = 1'b1;
        tick();
        tick();
        check("haz_score", 32'(score), 32'd1);
        frame_tick = 1'b1;
        hazard_hit = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        hazard_hit = 1'b0;
        check("haz_state", 32'(state), 32'(LOSE));
        check("haz_lose", 32'(round_lose), 32'd1);
        check("haz_nowin", 32'(round_win), 32'd0);
        p1_at_door = 1'b0;
        p2_at_door = 1'b0;
        gem_dead = 2'b00;
        pulse_start();
        check("haz_restart_clear", 32'(state), 32'(CLEAR));
        check("haz_restart_gem_clear", 32'(gem_clear), 32'd1);
        wait_state(PLAY, 10, "haz_restart_play");
        check("haz_restart_score", 32'(score), 32'd0);

        // asynchronous reset mid-PLAY
        gem_dead = 2'b11;
        repeat (4) tick();
        check("pre_rst_score", 32'(score), 32'd2);
        check("pre_rst_seconds", 32'(seconds), 32'd1);
        #2;
        Reset = 1'b0;
        #1;
        check("arst_state", 32'(state), 32'(IDLE));
        check("arst_score", 32'(score), 32'd0);
        check("arst_seconds", 32'(seconds), 32'd0);
        check("arst_freeze", 32'(freeze), 32'd1);
        check("arst_gem_clear", 32'(gem_clear), 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        check("post_rst_idle", 32'(state), 32'(IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
